// File: rtl/axi4_ar_sender.sv
// AXI4 read-address sender: captures one slave AR request, asks the address
// translation unit for a result, then either forwards the translated request
// on the master AR channel or hands it to the R sender as a drop.
module axi4_ar_sender #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 4
) (
   input  logic                      axi4_aclk,
   input  logic                      axi4_arst,
   // slave AR channel
   input  logic [AXI_ID_WIDTH-1:0]   s_axi4_arid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_araddr,
   input  logic [7:0]                s_axi4_arlen,
   input  logic [2:0]                s_axi4_arsize,
   input  logic [1:0]                s_axi4_arburst,
   input  logic                      s_axi4_arlock,
   input  logic [2:0]                s_axi4_arprot,
   input  logic [3:0]                s_axi4_arcache,
   input  logic [AXI_USER_WIDTH-1:0] s_axi4_aruser,
   input  logic                      s_axi4_arvalid,
   output logic                      s_axi4_arready,
   // translation lookup
   output logic                      lookup_valid_o,
   output logic [AXI_ADDR_WIDTH-1:0] lookup_addr_o,
   output logic [AXI_ID_WIDTH-1:0]   lookup_id_o,
   input  logic                      rsp_valid_i,
   input  logic                      rsp_accept_i,
   input  logic [AXI_ADDR_WIDTH-1:0] rsp_addr_i,
   input  logic                      rsp_prefetch_i,
   input  logic                      rsp_hit_i,
   // drop path towards the R sender
   output logic                      drop_o,
   output logic [7:0]                drop_len_o,
   output logic [AXI_ID_WIDTH-1:0]   drop_id_o,
   output logic                      drop_prefetch_o,
   output logic                      drop_hit_o,
   input  logic                      drop_done_i,
   // master AR channel
   output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
   output logic [7:0]                m_axi4_arlen,
   output logic [2:0]                m_axi4_arsize,
   output logic [1:0]                m_axi4_arburst,
   output logic                      m_axi4_arlock,
   output logic [2:0]                m_axi4_arprot,
   output logic [3:0]                m_axi4_arcache,
   output logic [AXI_USER_WIDTH-1:0] m_axi4_aruser,
   output logic                      m_axi4_arvalid,
   input  logic                      m_axi4_arready,
   // statistics
   output logic [15:0]               drop_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOOKUP  = 2'd1,
      ST_FORWARD = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   state_t                    state_r;
   state_t                    state_nxt_s;
   logic                      cap_en_s;
   logic                      rsp_en_s;
   logic                      cnt_en_s;
   logic [15:0]               drop_cnt_nxt_s;

   logic [AXI_ID_WIDTH-1:0]   arid_r;
   logic [AXI_ADDR_WIDTH-1:0] araddr_r;
   logic [7:0]                arlen_r;
   logic [2:0]                arsize_r;
   logic [1:0]                arburst_r;
   logic                      arlock_r;
   logic [2:0]                arprot_r;
   logic [3:0]                arcache_r;
   logic [AXI_USER_WIDTH-1:0] aruser_r;
   logic [AXI_ADDR_WIDTH-1:0] xaddr_r;
   logic                      prefetch_r;
   logic                      hit_r;
   logic [15:0]               drop_cnt_r;

   // Next-state decode plus the capture/response/count strobes.
   always_comb begin
      state_nxt_s = state_r;
      cap_en_s    = 1'b0;
      rsp_en_s    = 1'b0;
      cnt_en_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (s_axi4_arvalid) begin
               cap_en_s    = 1'b1;
               state_nxt_s = ST_LOOKUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            if (rsp_valid_i) begin
               rsp_en_s = 1'b1;
               if (rsp_accept_i) begin
                  state_nxt_s = ST_FORWARD;
               end else begin
                  state_nxt_s = ST_DROP;
               end
            end else begin
               state_nxt_s = ST_LOOKUP;
            end
         end
         ST_FORWARD: begin
            if (m_axi4_arready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FORWARD;
            end
         end
         ST_DROP: begin
            if (drop_done_i) begin
               cnt_en_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DROP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Saturating next value of the dropped-burst counter.
   always_comb begin
      drop_cnt_nxt_s = drop_cnt_r;
      if (cnt_en_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_nxt_s = drop_cnt_r + 16'd1;
      end else begin
         drop_cnt_nxt_s = drop_cnt_r;
      end
   end

   // State register and drop counter.
   always_ff @(posedge axi4_aclk) begin
      if (axi4_arst) begin
         state_r    <= ST_IDLE;
         drop_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_nxt_s;
         drop_cnt_r <= drop_cnt_nxt_s;
      end
   end

   // Request payload capture and translation result registers.
   always_ff @(posedge axi4_aclk) begin
      if (axi4_arst) begin
         arid_r     <= '0;
         araddr_r   <= '0;
         arlen_r    <= 8'd0;
         arsize_r   <= 3'd0;
         arburst_r  <= 2'd0;
         arlock_r   <= 1'b0;
         arprot_r   <= 3'd0;
         arcache_r  <= 4'd0;
         aruser_r   <= '0;
         xaddr_r    <= '0;
         prefetch_r <= 1'b0;
         hit_r      <= 1'b0;
      end else begin
         if (cap_en_s) begin
            arid_r    <= s_axi4_arid;
            araddr_r  <= s_axi4_araddr;
            arlen_r   <= s_axi4_arlen;
            arsize_r  <= s_axi4_arsize;
            arburst_r <= s_axi4_arburst;
            arlock_r  <= s_axi4_arlock;
            arprot_r  <= s_axi4_arprot;
            arcache_r <= s_axi4_arcache;
            aruser_r  <= s_axi4_aruser;
         end
         if (rsp_en_s) begin
            xaddr_r    <= rsp_addr_i;
            prefetch_r <= rsp_prefetch_i;
            hit_r      <= rsp_hit_i;
         end
      end
   end

   // Handshake flags come straight from the state register; they are held
   // low while reset is asserted so nothing leaks out during the reset cycle.
   assign s_axi4_arready  = (state_r == ST_IDLE)    && !axi4_arst;
   assign lookup_valid_o  = (state_r == ST_LOOKUP)  && !axi4_arst;
   assign m_axi4_arvalid  = (state_r == ST_FORWARD) && !axi4_arst;
   assign drop_o          = (state_r == ST_DROP)    && !axi4_arst;

   assign lookup_addr_o   = araddr_r;
   assign lookup_id_o     = arid_r;

   assign drop_len_o      = arlen_r;
   assign drop_id_o       = arid_r;
   assign drop_prefetch_o = prefetch_r;
   assign drop_hit_o      = hit_r;

   assign m_axi4_arid     = arid_r;
   assign m_axi4_araddr   = xaddr_r;
   assign m_axi4_arlen    = arlen_r;
   assign m_axi4_arsize   = arsize_r;
   assign m_axi4_arburst  = arburst_r;
   assign m_axi4_arlock   = arlock_r;
   assign m_axi4_arprot   = arprot_r;
   assign m_axi4_arcache  = arcache_r;
   assign m_axi4_aruser   = aruser_r;

   assign drop_cnt_o      = drop_cnt_r;

endmodule

// File: doc/axi4_ar_sender.md
AXI4_AR_SENDER -- requirements
Module: axi4_ar_sender

Interface
REQ-001 Parameters SHALL be:
- AXI_ADDR_WIDTH, default 32, address width.
- AXI_ID_WIDTH, default 4, ID width.
- AXI_USER_WIDTH, default 4, user width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- axi4_aclk, in, 1, clock.
- axi4_arst, in, 1, reset; one clock, reset is synchronous and active-high.
- s_axi4_arid/araddr/arlen/arsize/arburst/arlock/arprot/arcache/aruser, in, ID/ADDR/8/3/2/1/3/4/USER, slave AR payload.
- s_axi4_arvalid, in, 1, slave AR valid.
- s_axi4_arready, out, 1, slave AR ready.
- lookup_valid_o, out, 1, translation request.
- lookup_addr_o, out, ADDR, untranslated address.
- lookup_id_o, out, ID, request ID.
- rsp_valid_i, in, 1, translation result pulse.
- rsp_accept_i, in, 1, 1 = forward, 0 = drop.
- rsp_addr_i, in, ADDR, translated address.
- rsp_prefetch_i, in, 1, prefetch request flag.
- rsp_hit_i, in, 1, hit flag (multi-hit or protection fault).
- drop_o, out, 1, drop request to R sender.
- drop_len_o, out, 8, burst length (arlen).
- drop_id_o, out, ID, request ID.
- drop_prefetch_o, out, 1, prefetch flag.
- drop_hit_o, out, 1, hit flag.
- drop_done_i, in, 1, R sender accepted the drop (same-cycle).
- m_axi4_ar*, out, same widths as slave payload, master AR payload.
- m_axi4_arvalid, out, 1, master AR valid.
- m_axi4_arready, in, 1, master AR ready.
- drop_cnt_o, out, 16, saturating count of dropped bursts.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOOKUP, FORWARD, DROP.
REQ-004 s_axi4_arready SHALL be 1 only in IDLE; no other output depends combinationally on s_axi4_arvalid.
REQ-005 In IDLE with s_axi4_arvalid=1, the block SHALL capture the full slave payload into registers and go to LOOKUP on the next cycle.
REQ-006 In LOOKUP, lookup_valid_o SHALL be 1 and lookup_addr_o/lookup_id_o SHALL equal the captured araddr/arid.
REQ-007 In LOOKUP with rsp_valid_i=1, the block SHALL register rsp_addr_i, rsp_prefetch_i and rsp_hit_i, then go to FORWARD if rsp_accept_i=1, else to DROP.
REQ-008 rsp_valid_i SHALL be ignored in every state except LOOKUP.
REQ-009 In FORWARD:
- m_axi4_arvalid SHALL be 1.
- m_axi4_araddr SHALL equal the registered translated address.
- All other m_axi4_ar* fields SHALL equal the captured slave fields.
- The payload SHALL stay stable until m_axi4_arready=1, then the FSM SHALL return to IDLE.
REQ-010 In DROP:
- drop_o SHALL be 1.
- drop_len_o, drop_id_o, drop_prefetch_o and drop_hit_o SHALL equal the captured arlen, arid and registered flags.
- When drop_done_i=1, the FSM SHALL go to IDLE and drop_cnt_o SHALL increment by 1, saturating at 16'hFFFF.
REQ-011 m_axi4_arvalid and drop_o SHALL never both be 1.
REQ-012 Minimum occupancy SHALL be 3 cycles per burst: capture, lookup (response in the same cycle), issue accepted in the same cycle.
REQ-013 With s_axi4_arvalid held, the next capture SHALL occur in the cycle after the return to IDLE; at most one request is in flight.
REQ-014 The m_axi4_ar* payload outside FORWARD and the drop_* payload outside DROP are don't-care; the bench SHALL check them only while the matching valid is 1.

Reset
REQ-015 When axi4_arst=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear all captured registers and drop_cnt_o to 0;
- drive s_axi4_arready=0, lookup_valid_o=0, m_axi4_arvalid=0, drop_o=0 during the reset cycle.
REQ-016 A reset in LOOKUP, FORWARD or DROP SHALL discard the in-flight request with no handshake completed.
REQ-017 s_axi4_arready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-018 Accept: AR id=3 addr=0x1000 len=7; rsp_accept=1 addr=0x8000_1000; m_arready=1 -> one master AR with addr 0x8000_1000, id 3, len 7; issued 2 cycles after capture.
REQ-019 Drop: AR id=5 len=15; rsp_accept=0, prefetch=1, hit=0; drop_done=1 -> drop_o pulse with len 15, id 5, prefetch 1; drop_cnt_o=1; no master AR.
REQ-020 Backpressure:
- m_arready=0 for 10 cycles -> m_arvalid held with a stable payload and s_arready=0 throughout.
- drop_done=0 for 10 cycles -> drop_o held with a stable payload.
REQ-021 Back-to-back: s_arvalid held for 4 bursts with immediate responses -> 4 ordered issues, each 3 cycles apart; a stray rsp_valid_i pulse in FORWARD has no effect.
REQ-022 Reset in each of LOOKUP, FORWARD and DROP -> all valids 0 in the next cycle, drop_cnt_o=0, s_arready=1.
REQ-023 Saturation: preload 65535 drops, then one more drop -> drop_cnt_o stays 16'hFFFF.
